// File: rtl/saradc_11b_dig_seq_pkg.sv
// -----------------------------------------------------------------------------
// saradc_11b_dig_seq_pkg
// Shared types and default widths for the SAR ADC conversion sequencer.
//   seq_state_t : sequencer FSM states
//   seq_entry_t : one buffered conversion {chnr, result} at the default widths
// -----------------------------------------------------------------------------
package saradc_11b_dig_seq_pkg;

   localparam int CHNR_MSB_DEF    = 4;
   localparam int RESULT_MSB_DEF  = 10;
   localparam int SEQ_LEN_DEF     = 8;
   localparam int FIFO_DEPTH_DEF  = 4;
   localparam int TIMEOUT_CYC_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAKE  = 2'd1,
      ST_START = 2'd2,
      ST_CONV  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [CHNR_MSB_DEF:0]   chnr;
      logic [RESULT_MSB_DEF:0] result;
   } seq_entry_t;

endpackage

// File: rtl/saradc_11b_dig_seq_fifo.sv
// -----------------------------------------------------------------------------
// saradc_11b_dig_seq_fifo
// Synchronous first-word fall-through FIFO for the conversion results.
// Ports:
//   clk_i, res_i        clock, asynchronous active-high reset
//   wr_en_i, wr_data_i  push request and data
//   rd_en_i             pop request (ignored while empty)
//   rd_data_o           head entry, valid while empty_o = 0
//   empty_o, full_o     occupancy flags
//   level_o             number of stored entries
//   drop_o              push attempted while full with no simultaneous pop
// -----------------------------------------------------------------------------
module saradc_11b_dig_seq_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       res_i,
   input  logic                       wr_en_i,
   input  logic [W-1:0]               wr_data_i,
   input  logic                       rd_en_i,
   output logic [W-1:0]               rd_data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       drop_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] cnt_q, cnt_d;
   logic             do_wr_s, do_rd_s;

   assign empty_o   = (cnt_q == LVL_W'(0));
   assign full_o    = (cnt_q == LVL_W'(DEPTH));
   assign level_o   = cnt_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Pointer/count update; a pop frees a slot so a push into a full FIFO
   // in the same cycle is accepted.
   always_comb begin
      do_rd_s  = rd_en_i & ~empty_o;
      do_wr_s  = wr_en_i & (~full_o | do_rd_s);
      drop_o   = wr_en_i & full_o & ~do_rd_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_rd_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_wr_s, do_rd_s})
         2'b10:   cnt_d = cnt_q + LVL_W'(1);
         2'b01:   cnt_d = cnt_q - LVL_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer, count and storage registers.
   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
         end
      end
   end

endmodule

// File: rtl/saradc_11b_dig_conv_seq.sv
// -----------------------------------------------------------------------------
// saradc_11b_dig_conv_seq
// Conversion sequencer: wakes the analog module, walks a programmable channel
// list issuing start_adc/chnr, and buffers {chnr, result} on each eoc.
// Ports:
//   clk_i, res_i                   clock, asynchronous active-high reset
//   seq_start_i / seq_stop_i       sequence control pulses
//   seq_cont_i, seq_last_i,
//   seq_chnr_i                     list configuration (stable while busy)
//   mod_enable_o / mod_ready_i     analog module handshake
//   start_adc_o, chnr_o            conversion request and channel
//   eoc_i, result_i                conversion completion and data
//   rd_en_i, rd_data_o,
//   rd_valid_o, level_o            result FIFO read side
//   ovf_o, err_o                   sticky overflow / timeout flags
//   seq_busy_o, seq_done_o         status
// Build option: define SARADC_11B_SEQ_TIMEOUT_EN to enable the eoc watchdog
// (TIMEOUT_CYC cycles in CONV); otherwise err_o is constant 0.
// -----------------------------------------------------------------------------
module saradc_11b_dig_conv_seq
   import saradc_11b_dig_seq_pkg::*;
#(
   parameter int CHNR_MSB    = CHNR_MSB_DEF,
   parameter int RESULT_MSB  = RESULT_MSB_DEF,
   parameter int SEQ_LEN     = SEQ_LEN_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                              clk_i,
   input  logic                              res_i,
   input  logic                              seq_start_i,
   input  logic                              seq_stop_i,
   input  logic                              seq_cont_i,
   input  logic [$clog2(SEQ_LEN)-1:0]        seq_last_i,
   input  logic [SEQ_LEN*(CHNR_MSB+1)-1:0]   seq_chnr_i,
   output logic                              mod_enable_o,
   input  logic                              mod_ready_i,
   output logic                              start_adc_o,
   output logic [CHNR_MSB:0]                 chnr_o,
   input  logic                              eoc_i,
   input  logic [RESULT_MSB:0]               result_i,
   input  logic                              rd_en_i,
   output logic [CHNR_MSB+RESULT_MSB+1:0]    rd_data_o,
   output logic                              rd_valid_o,
   output logic [$clog2(FIFO_DEPTH):0]       level_o,
   output logic                              ovf_o,
   output logic                              err_o,
   output logic                              seq_busy_o,
   output logic                              seq_done_o
);

   localparam int CHNR_W = CHNR_MSB + 1;
   localparam int ENT_W  = CHNR_MSB + RESULT_MSB + 2;
   localparam int IDX_W  = $clog2(SEQ_LEN);

   seq_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              stop_q, stop_d;
   logic              mod_enable_q, mod_enable_d;
   logic              start_adc_q, start_adc_d;
   logic [CHNR_W-1:0] chnr_q, chnr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic              stop_eff_s;
   logic              push_s;
   logic              fifo_drop_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;

`ifdef SARADC_11B_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
`endif

   // Next-state, list walk and registered-output decode.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      stop_d     = stop_q;
      done_d     = 1'b0;
      push_s     = 1'b0;
      ovf_d      = ovf_q | fifo_drop_s;
      // A stop arriving in the same cycle as eoc still ends the sequence.
      stop_eff_s = stop_q | seq_stop_i;
`ifdef SARADC_11B_SEQ_TIMEOUT_EN
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (seq_start_i) begin
               state_d = ST_WAKE;
               idx_d   = '0;
               stop_d  = 1'b0;
               ovf_d   = 1'b0;
`ifdef SARADC_11B_SEQ_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAKE: begin
            if (seq_stop_i) begin
               state_d = ST_IDLE;
               stop_d  = 1'b1;
               done_d  = 1'b1;
            end else if (mod_ready_i) begin
               state_d = ST_START;
            end else begin
               state_d = ST_WAKE;
            end
         end
         ST_START: begin
            state_d = ST_CONV;
            stop_d  = stop_eff_s;
         end
         ST_CONV: begin
            stop_d = stop_eff_s;
            if (eoc_i) begin
               push_s = 1'b1;
               if (!stop_eff_s && (idx_q < seq_last_i)) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_START;
               end else if (!stop_eff_s && (idx_q == seq_last_i) && seq_cont_i) begin
                  idx_d   = '0;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
`ifdef SARADC_11B_SEQ_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
`endif
            else begin
               state_d = ST_CONV;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      mod_enable_d = (state_d != ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
      start_adc_d  = (state_d == ST_START);
      // Channel is latched on entry to START and held through CONV.
      if (state_d == ST_START) begin
         chnr_d = seq_chnr_i[idx_d*CHNR_W +: CHNR_W];
      end else begin
         chnr_d = chnr_q;
      end
   end

   // Sequencer state and output registers.
   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         stop_q       <= 1'b0;
         mod_enable_q <= 1'b0;
         start_adc_q  <= 1'b0;
         chnr_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         stop_q       <= stop_d;
         mod_enable_q <= mod_enable_d;
         start_adc_q  <= start_adc_d;
         chnr_q       <= chnr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
      end
   end

`ifdef SARADC_11B_SEQ_TIMEOUT_EN
   // Watchdog counts CONV cycles; it reads 0 on every entry to CONV.
   always_comb begin
      if (state_q == ST_CONV) begin
         tmo_d = tmo_q + TMO_W'(1);
      end else begin
         tmo_d = '0;
      end
   end

   // Watchdog counter and sticky timeout flag.
   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   // No watchdog: always 0; TIMEOUT_CYC stays referenced in both builds.
   assign err_o = (TIMEOUT_CYC < 0) ? 1'b1 : 1'b0;
`endif

   saradc_11b_dig_seq_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .res_i     (res_i),
      .wr_en_i   (push_s),
      .wr_data_i ({chnr_q, result_i}),
      .rd_en_i   (rd_en_i),
      .rd_data_o (rd_data_o),
      .empty_o   (fifo_empty_s),
      .full_o    (fifo_full_s),
      .level_o   (level_o),
      .drop_o    (fifo_drop_s)
   );

   assign mod_enable_o = mod_enable_q;
   assign start_adc_o  = start_adc_q;
   assign chnr_o       = chnr_q;
   assign rd_valid_o   = ~fifo_empty_s;
   assign ovf_o        = ovf_q;
   assign seq_busy_o   = busy_q;
   assign seq_done_o   = done_q;

   // Full flag is only needed inside the FIFO; keep it observable for debug.
   logic fifo_full_dbg_s;
   assign fifo_full_dbg_s = fifo_full_s;

endmodule

// File: tb/tb_saradc_11b_dig_conv_seq.sv
// -----------------------------------------------------------------------------
// tb_saradc_11b_dig_conv_seq
// Scenario tasks drive the sequencer as the analog side; expected FIFO entries
// are queued when eoc is driven and compared when popped.
// -----------------------------------------------------------------------------
module tb_saradc_11b_dig_conv_seq;
   import saradc_11b_dig_seq_pkg::*;

   localparam int CW  = 5;
   localparam int RW  = 11;
   localparam int SL  = 8;
   localparam int TMO = 20;

   logic          clk = 1'b0;
   logic          res;
   logic          seq_start, seq_stop, seq_cont;
   logic [2:0]    seq_last;
   logic [SL*CW-1:0] seq_chnr;
   logic          mod_enable, mod_ready, start_adc;
   logic [CW-1:0] chnr;
   logic          eoc;
   logic [RW-1:0] result;
   logic          rd_en;
   logic [CW+RW-1:0] rd_data;
   logic          rd_valid;
   logic [2:0]    level;
   logic          ovf, err, seq_busy, seq_done;

   int checks   = 0;
   int failures = 0;
   int n_start  = 0;
   int n_done   = 0;
   seq_entry_t sb[$];

   always #5 clk = ~clk;

   saradc_11b_dig_conv_seq #(.TIMEOUT_CYC(TMO)) dut (
      .clk_i(clk), .res_i(res),
      .seq_start_i(seq_start), .seq_stop_i(seq_stop), .seq_cont_i(seq_cont),
      .seq_last_i(seq_last), .seq_chnr_i(seq_chnr),
      .mod_enable_o(mod_enable), .mod_ready_i(mod_ready),
      .start_adc_o(start_adc), .chnr_o(chnr),
      .eoc_i(eoc), .result_i(result),
      .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
      .level_o(level), .ovf_o(ovf), .err_o(err),
      .seq_busy_o(seq_busy), .seq_done_o(seq_done)
   );

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (start_adc === 1'b1) n_start++;
      if (seq_done === 1'b1) n_done++;
   end

   function automatic seq_entry_t mk(input logic [CW-1:0] c, input logic [RW-1:0] r);
      seq_entry_t e;
      e.chnr   = c;
      e.result = r;
      return e;
   endfunction

   task automatic set_list(input logic [CW-1:0] c0, c1, c2, c3);
      seq_chnr        = '0;
      seq_chnr[4:0]   = c0;
      seq_chnr[9:5]   = c1;
      seq_chnr[14:10] = c2;
      seq_chnr[19:15] = c3;
   endtask

   task automatic pulse_start();
      seq_start = 1'b1;
      @(negedge clk);
      seq_start = 1'b0;
   endtask

   // Returns at the first negedge (current one included) showing start_adc.
   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (start_adc === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      res = 1'b1; seq_start = 1'b0; seq_stop = 1'b0; seq_cont = 1'b0;
      seq_last = 3'd0; seq_chnr = '0; mod_ready = 1'b0; eoc = 1'b0;
      result = '0; rd_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mod_enable, start_adc, seq_busy, seq_done, rd_valid, ovf, err} !== 7'd0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {mod_enable, start_adc, seq_busy, seq_done, rd_valid, ovf, err});
      end
      checks++;
      if (level !== 3'd0 || chnr !== 5'd0 || rd_data !== 16'd0) begin
         failures++;
         $display("FAIL reset_values: level=%0d chnr=%0d rd_data=%h expected 0/0/0", level, chnr, rd_data);
      end
      res = 1'b0;
      @(negedge clk);
      checks++;
      if (seq_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_busy: got %b expected 0", seq_busy);
      end
   endtask

   task automatic test_basic();
      logic [CW-1:0] chl [3];
      logic [RW-1:0] rsl [3];
      int s0, d0;
      bit ok;
      seq_entry_t exp;
      chl = '{5'd3, 5'd7, 5'd12};
      rsl = '{11'h100, 11'h2AA, 11'h7FF};
      set_list(5'd3, 5'd7, 5'd12, 5'd0);
      seq_last = 3'd2; seq_cont = 1'b0; mod_ready = 1'b0;
      s0 = n_start; d0 = n_done;
      pulse_start();
      checks++;
      if (mod_enable !== 1'b1 || start_adc !== 1'b0) begin
         failures++;
         $display("FAIL basic_enable: mod_enable=%b start_adc=%b expected 1/0", mod_enable, start_adc);
      end
      repeat (4) @(negedge clk);
      mod_ready = 1'b1;
      @(negedge clk);
      wait_start(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL basic_first_start: no start_adc within bound");
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (chnr !== chl[i]) begin
            failures++;
            $display("FAIL basic_chnr%0d: got %0d expected %0d", i, chnr, chl[i]);
         end
         repeat (9) @(negedge clk);
         eoc = 1'b1; result = rsl[i];
         sb.push_back(mk(chl[i], rsl[i]));
         @(negedge clk);
         eoc = 1'b0;
         checks++;
         if (level !== 3'(i + 1)) begin
            failures++;
            $display("FAIL basic_level%0d: got %0d expected %0d", i, level, i + 1);
         end
         checks++;
         if (i < 2) begin
            if (start_adc !== 1'b1) begin
               failures++;
               $display("FAIL basic_next_start%0d: got %b expected 1", i, start_adc);
            end
         end else begin
            if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
               failures++;
               $display("FAIL basic_done: done=%b busy=%b expected 1/0", seq_done, seq_busy);
            end
         end
      end
      mod_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (n_start - s0 !== 3 || n_done - d0 !== 1) begin
         failures++;
         $display("FAIL basic_pulse_counts: starts=%0d dones=%0d expected 3/1", n_start - s0, n_done - d0);
      end
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp) begin
            failures++;
            $display("FAIL basic_pop: got valid=%b data=%h expected 1/%h", rd_valid, rd_data, exp);
         end
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
   endtask

   task automatic test_overflow();
      bit ok;
      seq_entry_t exp;
      logic [CW-1:0] c;
      set_list(5'd5, 5'd9, 5'd0, 5'd0);
      seq_last = 3'd1; seq_cont = 1'b1; mod_ready = 1'b1;
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         wait_start(ok);
         c = ((k % 2) == 1) ? 5'd9 : 5'd5;
         checks++;
         if (!ok || chnr !== c) begin
            failures++;
            $display("FAIL ovf_start%0d: ok=%b chnr=%0d expected 1/%0d", k, ok, chnr, c);
         end
         repeat (2) @(negedge clk);
         eoc = 1'b1; result = 11'h010 + 11'(k);
         if (k < 4) sb.push_back(mk(c, 11'h010 + 11'(k)));
         @(negedge clk);
         eoc = 1'b0;
         if (k == 3) begin
            checks++;
            if (ovf !== 1'b0 || level !== 3'd4) begin
               failures++;
               $display("FAIL ovf_full_no_ovf: ovf=%b level=%0d expected 0/4", ovf, level);
            end
         end
      end
      checks++;
      if (ovf !== 1'b1 || level !== 3'd4) begin
         failures++;
         $display("FAIL ovf_set: ovf=%b level=%0d expected 1/4", ovf, level);
      end
      // Stop during the next conversion; its result is dropped (FIFO full).
      seq_stop = 1'b1;
      @(negedge clk);
      seq_stop = 1'b0;
      @(negedge clk);
      eoc = 1'b1; result = 11'h0EE;
      @(negedge clk);
      eoc = 1'b0;
      checks++;
      if (seq_done !== 1'b1 || level !== 3'd4) begin
         failures++;
         $display("FAIL ovf_stop_done: done=%b level=%0d expected 1/4", seq_done, level);
      end
      // Restart clears ovf; a push together with a pop while full succeeds.
      pulse_start();
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear_on_start: got %b expected 0", ovf);
      end
      wait_start(ok);
      seq_stop = 1'b1;
      @(negedge clk);
      seq_stop = 1'b0;
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (rd_data !== exp) begin
         failures++;
         $display("FAIL ovf_head: got %h expected %h", rd_data, exp);
      end
      eoc = 1'b1; result = 11'h3C3; rd_en = 1'b1;
      sb.push_back(mk(5'd5, 11'h3C3));
      @(negedge clk);
      eoc = 1'b0; rd_en = 1'b0;
      checks++;
      if (ovf !== 1'b0 || level !== 3'd4 || seq_done !== 1'b1) begin
         failures++;
         $display("FAIL ovf_push_pop_full: ovf=%b level=%0d done=%b expected 0/4/1", ovf, level, seq_done);
      end
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp) begin
            failures++;
            $display("FAIL ovf_pop: got valid=%b data=%h expected 1/%h", rd_valid, rd_data, exp);
         end
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
      checks++;
      if (rd_valid !== 1'b0 || level !== 3'd0) begin
         failures++;
         $display("FAIL ovf_drained: valid=%b level=%0d expected 0/0", rd_valid, level);
      end
      seq_cont = 1'b0; mod_ready = 1'b0;
   endtask

   task automatic test_stop();
      bit ok;
      int s0;
      seq_entry_t exp;
      set_list(5'd1, 5'd2, 5'd3, 5'd4);
      seq_last = 3'd3; seq_cont = 1'b0; mod_ready = 1'b1;
      s0 = n_start;
      pulse_start();
      wait_start(ok);
      checks++;
      if (!ok || chnr !== 5'd1) begin
         failures++;
         $display("FAIL stop_first: ok=%b chnr=%0d expected 1/1", ok, chnr);
      end
      @(negedge clk);
      seq_stop = 1'b1;
      @(negedge clk);
      seq_stop = 1'b0;
      repeat (3) @(negedge clk);
      eoc = 1'b1; result = 11'h155;
      sb.push_back(mk(5'd1, 11'h155));
      @(negedge clk);
      eoc = 1'b0;
      checks++;
      if (seq_done !== 1'b1 || level !== 3'd1) begin
         failures++;
         $display("FAIL stop_done: done=%b level=%0d expected 1/1", seq_done, level);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (n_start - s0 !== 1 || seq_busy !== 1'b0) begin
         failures++;
         $display("FAIL stop_no_more_start: starts=%0d busy=%b expected 1/0", n_start - s0, seq_busy);
      end
      exp = sb.pop_front();
      checks++;
      if (rd_data !== exp) begin
         failures++;
         $display("FAIL stop_data: got %h expected %h", rd_data, exp);
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      mod_ready = 1'b0;
   endtask

   task automatic test_eoc_ignored();
      seq_entry_t exp;
      set_list(5'd6, 5'd0, 5'd0, 5'd0);
      seq_last = 3'd0; seq_cont = 1'b0; mod_ready = 1'b0;
      eoc = 1'b1; result = 11'h0AA;
      @(negedge clk);
      eoc = 1'b0;
      @(negedge clk);
      checks++;
      if (level !== 3'd0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL eoc_idle: level=%0d valid=%b expected 0/0", level, rd_valid);
      end
      pulse_start();
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      mod_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (start_adc !== 1'b1) begin
         failures++;
         $display("FAIL eoc_reach_start: start_adc=%b expected 1", start_adc);
      end
      eoc = 1'b1; result = 11'h0BB;
      @(negedge clk);
      eoc = 1'b0;
      checks++;
      if (level !== 3'd0 || seq_busy !== 1'b1) begin
         failures++;
         $display("FAIL eoc_start: level=%0d busy=%b expected 0/1", level, seq_busy);
      end
      repeat (2) @(negedge clk);
      eoc = 1'b1; result = 11'h0CC;
      sb.push_back(mk(5'd6, 11'h0CC));
      @(negedge clk);
      eoc = 1'b0;
      exp = sb.pop_front();
      checks++;
      if (level !== 3'd1 || rd_data !== exp || seq_done !== 1'b1) begin
         failures++;
         $display("FAIL eoc_conv: level=%0d data=%h done=%b expected 1/%h/1", level, rd_data, seq_done, exp);
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      mod_ready = 1'b0;
   endtask

   task automatic test_wake_stop();
      mod_ready = 1'b0;
      pulse_start();
      checks++;
      if (seq_busy !== 1'b1) begin
         failures++;
         $display("FAIL wake_busy: got %b expected 1", seq_busy);
      end
      seq_stop = 1'b1;
      @(negedge clk);
      seq_stop = 1'b0;
      checks++;
      if (seq_done !== 1'b1 || seq_busy !== 1'b0 || mod_enable !== 1'b0) begin
         failures++;
         $display("FAIL wake_stop: done=%b busy=%b en=%b expected 1/0/0", seq_done, seq_busy, mod_enable);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      set_list(5'd2, 5'd4, 5'd6, 5'd8);
      seq_last = 3'd3; seq_cont = 1'b0; mod_ready = 1'b1;
      pulse_start();
      for (int k = 0; k < 2; k++) begin
         wait_start(ok);
         repeat (2) @(negedge clk);
         eoc = 1'b1; result = 11'h200 + 11'(k);
         sb.push_back(mk((k == 0) ? 5'd2 : 5'd4, 11'h200 + 11'(k)));
         @(negedge clk);
         eoc = 1'b0;
      end
      wait_start(ok);
      @(negedge clk);
      checks++;
      if (level !== 3'd2 || seq_busy !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_before: level=%0d busy=%b expected 2/1", level, seq_busy);
      end
      res = 1'b1;
      sb.delete();
      #1;
      checks++;
      if (level !== 3'd0 || mod_enable !== 1'b0 || seq_busy !== 1'b0 || rd_valid !== 1'b0 || chnr !== 5'd0) begin
         failures++;
         $display("FAIL rstmid_after: level=%0d en=%b busy=%b valid=%b chnr=%0d expected 0/0/0/0/0",
                  level, mod_enable, seq_busy, rd_valid, chnr);
      end
      @(negedge clk);
      res = 1'b0; mod_ready = 1'b0;
      @(negedge clk);
   endtask

`ifdef SARADC_11B_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      set_list(5'd10, 5'd0, 5'd0, 5'd0);
      seq_last = 3'd0; seq_cont = 1'b0; mod_ready = 1'b1;
      pulse_start();
      wait_start(ok);
      repeat (TMO) @(negedge clk);
      checks++;
      if (err !== 1'b0 || seq_busy !== 1'b1) begin
         failures++;
         $display("FAIL tmo_early: err=%b busy=%b expected 0/1", err, seq_busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || seq_done !== 1'b1 || seq_busy !== 1'b0 || level !== 3'd0) begin
         failures++;
         $display("FAIL tmo_fire: err=%b done=%b busy=%b level=%0d expected 1/1/0/0", err, seq_done, seq_busy, level);
      end
      mod_ready = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_stop();
      test_eoc_ignored();
      test_wake_stop();
      test_reset_mid();
`ifdef SARADC_11B_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
